// File: rtl/law_check_sequencer_pkg.sv
// Shared state encoding and default sizing for the Boolean-law check sequencer.
package law_check_sequencer_pkg;

    localparam int unsigned DEF_N_IN   = 2;
    localparam int unsigned DEF_N_LAW  = 2;
    localparam int unsigned DEF_SETTLE = 1;
    // Settle counter width covers the legal SETTLE range 1..15
    localparam int unsigned WAIT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/law_check_sequencer_if.sv
// Datapath drive/sample and result bus between the sequencer and its surroundings.
interface law_check_sequencer_if
    import law_check_sequencer_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_LAW = DEF_N_LAW
);
    logic             start;
    logic [N_IN-1:0]  vec;
    logic [N_LAW-1:0] lhs;
    logic [N_LAW-1:0] rhs;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_cnt;
    logic             fail_valid;
    logic [N_IN-1:0]  fail_vec;
    logic [N_LAW-1:0] fail_law;

    modport master (
        output start, lhs, rhs,
        input  vec, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_law
    );

    modport slave (
        input  start, lhs, rhs,
        output vec, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_law
    );
endinterface

// File: rtl/law_check_sequencer_law_cmp.sv
// Combinational LHS/RHS comparator: per-law mismatch mask plus an any-mismatch flag.
module law_cmp
    import law_check_sequencer_pkg::*;
#(
    parameter int unsigned N_LAW = DEF_N_LAW
) (
    input  logic [N_LAW-1:0] i_lhs,
    input  logic [N_LAW-1:0] i_rhs,
    output logic [N_LAW-1:0] o_mis_c,
    output logic             o_any_mis_c
);
    assign o_mis_c     = i_lhs ^ i_rhs;
    assign o_any_mis_c = |o_mis_c;
endmodule

// File: rtl/law_check_sequencer.sv
// Walks every input vector through a combinational law datapath, counting
// LHS/RHS mismatches and capturing the first failing vector.
module law_check_sequencer
    import law_check_sequencer_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned N_LAW  = DEF_N_LAW,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst,
    law_check_sequencer_if.slave bus
);
    localparam int unsigned ERR_W = N_IN + 1;

    state_t             r_state, w_state;
    logic [N_IN-1:0]    r_vec, w_vec;
    logic [WAIT_W-1:0]  r_wait, w_wait;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_pass, w_pass;
    logic [ERR_W-1:0]   r_err, w_err;
    logic               r_fv, w_fv;
    logic [N_IN-1:0]    r_fvec, w_fvec;
    logic [N_LAW-1:0]   r_flaw, w_flaw;
    logic [N_LAW-1:0]   w_mis;
    logic               w_any_mis;

    law_cmp #(.N_LAW(N_LAW)) u_law_cmp (
        .i_lhs       (bus.lhs),
        .i_rhs       (bus.rhs),
        .o_mis_c     (w_mis),
        .o_any_mis_c (w_any_mis)
    );

    // Next-state and next-result logic
    always_comb begin
        w_state = r_state;
        w_vec   = r_vec;
        w_wait  = r_wait;
        w_pass  = r_pass;
        w_err   = r_err;
        w_fv    = r_fv;
        w_fvec  = r_fvec;
        w_flaw  = r_flaw;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_vec   = '0;
                    w_wait  = '0;
                    w_err   = '0;
                    w_fv    = 1'b0;
                    w_fvec  = '0;
                    w_flaw  = '0;
                    w_pass  = 1'b0;
                    w_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_wait == WAIT_W'(SETTLE - 1)) begin
                    w_state = S_SAMPLE;
                end else begin
                    w_wait = r_wait + WAIT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (w_any_mis) begin
                    w_err = r_err + ERR_W'(1);
                end
                // Only the first failure of a run is captured
                if (w_any_mis && !r_fv) begin
                    w_fv   = 1'b1;
                    w_fvec = r_vec;
                    w_flaw = w_mis;
                end
                if (r_vec == '1) begin
                    w_pass  = (r_err == '0) && !w_any_mis;
                    w_state = S_DONE;
                end else begin
                    w_vec   = r_vec + N_IN'(1);
                    w_wait  = '0;
                    w_state = S_SETTLE;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        w_busy = (w_state == S_SETTLE) || (w_state == S_SAMPLE);
        w_done = (w_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_fvec  <= '0;
            r_flaw  <= '0;
        end else begin
            r_state <= w_state;
            r_vec   <= w_vec;
            r_wait  <= w_wait;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_fv    <= w_fv;
            r_fvec  <= w_fvec;
            r_flaw  <= w_flaw;
        end
    end

    assign bus.vec        = r_vec;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_cnt    = r_err;
    assign bus.fail_valid = r_fv;
    assign bus.fail_vec   = r_fvec;
    assign bus.fail_law   = r_flaw;
endmodule

// File: tb/tb_law_check_sequencer.sv
// Bench: two sequencers (SETTLE=1 and SETTLE=3) driving a modelled absorption datapath with injectable faults.
module tb_law_check_sequencer;
    import law_check_sequencer_pkg::*;

    localparam int unsigned N_IN  = 2;
    localparam int unsigned N_LAW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    law_check_sequencer_if #(.N_IN(N_IN), .N_LAW(N_LAW)) bus0 ();
    law_check_sequencer_if #(.N_IN(N_IN), .N_LAW(N_LAW)) bus1 ();

    law_check_sequencer #(.N_IN(N_IN), .N_LAW(N_LAW), .SETTLE(1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave));
    law_check_sequencer #(.N_IN(N_IN), .N_LAW(N_LAW), .SETTLE(3)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave));

    // 0 = correct, 1 = OR-law LHS stuck-at-0, 2 = AND-law RHS inverted
    int fault0 = 0;
    int fault1 = 0;

    function automatic logic [N_LAW-1:0] dp_lhs(input logic [N_IN-1:0] v, input int f);
        logic x, y;
        logic [N_LAW-1:0] l;
        x = v[1];
        y = v[0];
        l[0] = x & (x | y);
        l[1] = x | (x & y);
        if (f == 1) l[1] = 1'b0;
        return l;
    endfunction

    function automatic logic [N_LAW-1:0] dp_rhs(input logic [N_IN-1:0] v, input int f);
        logic [N_LAW-1:0] r;
        r = {v[1], v[1]};
        if (f == 2) r[0] = ~v[1];
        return r;
    endfunction

    always_comb begin
        bus0.lhs = dp_lhs(bus0.vec, fault0);
        bus0.rhs = dp_rhs(bus0.vec, fault0);
        bus1.lhs = dp_lhs(bus1.vec, fault1);
        bus1.rhs = dp_rhs(bus1.vec, fault1);
    end

    typedef struct {
        int vec, busy, done, pass, err, fv, fvec, flaw;
    } obs_t;

    typedef struct {
        int d, settle, fault;
        int err, fv, fvec, flaw, pass;
    } rec_t;

    rec_t tbl[6];
    rec_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic obs_t get_obs(input int d);
        obs_t o;
        if (d == 0) begin
            o.vec = int'(bus0.vec); o.busy = int'(bus0.busy); o.done = int'(bus0.done);
            o.pass = int'(bus0.pass); o.err = int'(bus0.err_cnt); o.fv = int'(bus0.fail_valid);
            o.fvec = int'(bus0.fail_vec); o.flaw = int'(bus0.fail_law);
        end else begin
            o.vec = int'(bus1.vec); o.busy = int'(bus1.busy); o.done = int'(bus1.done);
            o.pass = int'(bus1.pass); o.err = int'(bus1.err_cnt); o.fv = int'(bus1.fail_valid);
            o.fvec = int'(bus1.fail_vec); o.flaw = int'(bus1.fail_law);
        end
        return o;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) bus0.start = v;
        else        bus1.start = v;
    endtask

    task automatic set_fault(input int d, input int f);
        if (d == 0) fault0 = f;
        else        fault1 = f;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_results(input string tag, input obs_t o, input rec_t e);
        chk({tag, " err_cnt"},    o.err,  e.err);
        chk({tag, " fail_valid"}, o.fv,   e.fv);
        chk({tag, " fail_vec"},   o.fvec, e.fvec);
        chk({tag, " fail_law"},   o.flaw, e.flaw);
        chk({tag, " pass"},       o.pass, e.pass);
    endtask

    task automatic chk_reset(input string tag, input obs_t o);
        chk({tag, " vec"},  o.vec,  0);
        chk({tag, " busy"}, o.busy, 0);
        chk({tag, " done"}, o.done, 0);
        chk({tag, " pass"}, o.pass, 0);
        chk({tag, " err"},  o.err,  0);
        chk({tag, " fv"},   o.fv,   0);
        chk({tag, " fvec"}, o.fvec, 0);
        chk({tag, " flaw"}, o.flaw, 0);
    endtask

    // One full run: start accepted, vector stepping checked each cycle, results popped on done
    task automatic do_run(input rec_t e, input bit repulse, input bit hold);
        obs_t o;
        int   total, done_cyc;
        rec_t x;
        total = 4 * (e.settle + 1);
        done_cyc = 0;
        set_fault(e.d, e.fault);
        @(negedge clk);
        set_start(e.d, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(e.d, 1'b0);
        sb.push_back(e);
        for (int c = 1; c <= total + 6 && done_cyc == 0; c++) begin
            @(negedge clk);
            o = get_obs(e.d);
            if (repulse && !hold) set_start(e.d, (c == 3 || c == 5) ? 1'b1 : 1'b0);
            if (c <= total) begin
                chk("vec_step", o.vec, (c - 1) / (e.settle + 1));
                chk("busy_run", o.busy, 1);
                chk("done_early", o.done, 0);
            end
            if (o.done) done_cyc = c;
        end
        chk("done_cycle", done_cyc, total + 1);
        if (done_cyc != 0 && sb.size() > 0) begin
            x = sb.pop_front();
            chk("busy_at_done", o.busy, 0);
            chk_results("run", o, x);
        end else if (sb.size() > 0) begin
            x = sb.pop_front();
        end
    endtask

    initial begin
        obs_t o;
        int   seen;
        tbl[0] = '{d:0, settle:1, fault:0, err:0, fv:0, fvec:0, flaw:0, pass:1};
        tbl[1] = '{d:0, settle:1, fault:1, err:2, fv:1, fvec:2, flaw:2, pass:0};
        tbl[2] = '{d:0, settle:1, fault:2, err:4, fv:1, fvec:0, flaw:1, pass:0};
        tbl[3] = '{d:0, settle:1, fault:0, err:0, fv:0, fvec:0, flaw:0, pass:1};
        tbl[4] = '{d:1, settle:3, fault:0, err:0, fv:0, fvec:0, flaw:0, pass:1};
        tbl[5] = '{d:1, settle:3, fault:1, err:2, fv:1, fvec:2, flaw:2, pass:0};

        rst = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset0", get_obs(0));
        chk_reset("reset1", get_obs(1));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) do_run(tbl[i], 1'b0, 1'b0);

        // Results hold while idle
        repeat (4) @(negedge clk);
        o = get_obs(1);
        chk("idle_hold err", o.err, 2);
        chk("idle_hold pass", o.pass, 0);
        chk("idle_hold busy", o.busy, 0);

        // Start re-pulsed while busy has no effect
        do_run(tbl[0], 1'b1, 1'b0);

        // Start held through DONE: a second run begins right after returning to IDLE
        do_run(tbl[1], 1'b0, 1'b1);
        @(negedge clk);
        o = get_obs(0);
        chk("hold idle busy", o.busy, 0);
        chk("hold idle done", o.done, 0);
        fault0 = 0;
        @(negedge clk);
        o = get_obs(0);
        chk("hold rerun busy", o.busy, 1);
        chk("hold rerun err", o.err, 0);
        chk("hold rerun fv", o.fv, 0);
        chk("hold rerun vec", o.vec, 0);
        bus0.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 12 && seen == 0; c++) begin
            @(negedge clk);
            o = get_obs(0);
            if (o.done) seen = 1;
        end
        chk("hold rerun done_seen", seen, 1);
        chk_results("hold rerun", o, tbl[0]);

        // Reset during SAMPLE of vec=2 aborts with no done pulse
        fault0 = 1;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort vec", get_obs(0).vec, 2);
        rst = 1'b1;
        #1;
        chk_reset("abort", get_obs(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            o = get_obs(0);
            if (o.done || o.busy) seen = 1;
        end
        chk("abort no_activity", seen, 0);
        do_run(tbl[0], 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/law_check_sequencer.md
Name: law_check_sequencer

Overview:
Self-checking sequencer for a combinational Boolean-law datapath, such as the two-input absorption block with its AND-law and OR-law LHS/RHS pairs. On a start request it drives every input vector onto the datapath in ascending order and waits a fixed settle time. It then compares each law's LHS against its RHS, counts the failing vectors and records the first failure. It replaces hand-written monitor benches with a reusable on-chip checker.

Parameters:
N_IN, 2, width of the input vector driven to the datapath (vec[1]=x, vec[0]=y for the absorption block)
N_LAW, 2, number of LHS/RHS pairs checked (bit 0 = AND law, bit 1 = OR law)
SETTLE, 1, cycles between driving a vector and sampling it; legal range 1..15

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  run request; sampled only in IDLE
vec  output  N_IN  vector driven to the datapath under test
lhs  input  N_LAW  LHS result per law from the datapath
rhs  input  N_LAW  RHS result per law from the datapath
busy  output  1  high from the cycle after start is accepted until DONE is reached
done  output  1  one-cycle pulse in the DONE state
pass  output  1  high when the last completed run had zero failures
err_cnt  output  N_IN+1  number of vectors with any law mismatch
fail_valid  output  1  at least one failure recorded in the last run
fail_vec  output  N_IN  first failing vector
fail_law  output  N_LAW  mismatch mask (lhs^rhs) at the first failing vector

Behaviour:
- Reset values (async, active-high): state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0, fail_law=0, wait_cnt=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> vec<=0, wait_cnt<=0, err_cnt<=0, fail_valid<=0, fail_vec<=0, fail_law<=0, pass<=0, go to SETTLE.
  - start=0 -> stay; all result outputs hold the previous run's values.
- SETTLE: if wait_cnt==SETTLE-1 go to SAMPLE, else wait_cnt<=wait_cnt+1. vec is held stable.
- SAMPLE: mis = lhs ^ rhs.
  - If mis!=0: err_cnt<=err_cnt+1.
  - If mis!=0 and fail_valid==0: fail_vec<=vec, fail_law<=mis, fail_valid<=1. Later failures never overwrite these.
  - If vec==all-ones: go to DONE and set pass<=(err_cnt==0 && mis==0).
  - Otherwise: vec<=vec+1, wait_cnt<=0, go to SETTLE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE. start is ignored during DONE.
- busy is a registered output equal to (state==SETTLE || state==SAMPLE).
- Latency per vector is SETTLE+1 cycles. A full run takes 2^N_IN*(SETTLE+1) cycles from the accepting edge to the DONE entry. With the defaults this is 8 cycles, and done is high in the 9th cycle.
- err_cnt is N_IN+1 bits wide and cannot overflow, because its maximum value is 2^N_IN.
- vec never wraps within a run; the run terminates at all-ones.
- start is ignored whenever state!=IDLE. No queuing: a start held high through DONE is accepted again on the first cycle back in IDLE.
- rst asserted mid-run aborts immediately to the reset values, with no done pulse.
- X on lhs/rhs is the datapath's responsibility and is not filtered.

Decomposition:
- Shared package: the FSM state encoding (2-bit localparams IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and default parameter constants.
- One natural sub-module, law_cmp: purely combinational. It produces the mis mask and an any_mis flag from lhs/rhs. It is reused by future law checkers (distributive, De Morgan).
- The FSM, vector counter and result registers stay in the top block.

Test Plan:
- Correct absorption datapath, defaults, start pulse at t0 -> vec steps 0,1,2,3 every 2 cycles; done in cycle 9; pass=1, err_cnt=0, fail_valid=0.
- OR-law LHS stuck-at-0 -> mismatches at vec=2 and vec=3; err_cnt=2, fail_vec=2'b10, fail_law=2'b10, pass=0.
- AND-law RHS inverted -> all 4 vectors fail; err_cnt=4 (no overflow), fail_vec=0, fail_law=2'b01.
- start re-pulsed at cycles 3 and 5 while busy -> no effect; run finishes with done in cycle 9; a start held through DONE begins a second run in the following cycle with err_cnt cleared.
- rst pulsed during SAMPLE of vec=2 -> all outputs return to reset values within the same cycle; no done pulse; the next start runs cleanly from vec=0.
- SETTLE=3 -> each vector held for 3 cycles before sampling; the run takes 16 cycles; results match the defaults case.
